// File: rtl/mult_arb_pkg.sv
// ---------------------------------------------------------------------------
// mult_arb_pkg
// Shared definitions for the multiplier arbiter: FSM state type, default
// requester count / grant-index width, default watchdog limit, and a helper
// that sizes an index for a given requester count.
// Optional feature macro used by the arbiter: MULT_ARB_WATCHDOG_EN.
// ---------------------------------------------------------------------------
package mult_arb_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int IDW         = $clog2(DEF_NREQ);
    localparam int DEF_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin find-first-set. Scans i_req starting at i_ptr
// and moving upward, wrapping modulo NREQ.
// Ports:
//   i_req  [NREQ]   request vector
//   i_ptr  [IDW_L]  scan start position
//   o_gnt  [IDW_L]  index of the first set request at/after i_ptr
//   o_any  [1]      any request set (o_gnt meaningful only when high)
// ---------------------------------------------------------------------------
module rr_picker
    import mult_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW_L = idw_of(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDW_L-1:0] i_ptr,
    output logic [IDW_L-1:0] o_gnt,
    output logic             o_any
);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        o_gnt = '0;
        w_idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (i_req[w_idx]) o_gnt = IDW_L'(w_idx);
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/mult_arbiter.sv
// ---------------------------------------------------------------------------
// mult_arbiter
// Shares one W x W multiplier among NREQ requesters. A round-robin winner's
// operands are latched, the multiplier is started with a one-cycle pulse,
// and the product is returned to that requester on a one-cycle strobe.
// Optional watchdog: define MULT_ARB_WATCHDOG_EN to abort a multiply that
// has not completed within TIMEOUT cycles of BUSY (resp_err=1, resp_p=0,
// one-cycle mult_rst pulse).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready per-requester request / one-hot accept pulse
//   req_a/req_b         packed operands, requester i at [i*W +: W]
//   resp_valid          one-hot product strobe
//   resp_p/resp_err     product and watchdog-abort flag
//   mult_rst/start/a/b  multiplier control and latched operands
//   mult_done/mult_p    multiplier completion pulse and product
//   busy, grant_id      FSM not idle, index of the current owner
// ---------------------------------------------------------------------------
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int W       = 256,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int IDW_L  = idw_of(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     resp_valid,
    output logic [2*W-1:0]      resp_p,
    output logic                resp_err,
    output logic                mult_rst,
    output logic                mult_start,
    output logic [W-1:0]        mult_a,
    output logic [W-1:0]        mult_b,
    input  logic                mult_done,
    input  logic [2*W-1:0]      mult_p,
    output logic                busy,
    output logic [IDW_L-1:0]    grant_id
);

    state_t            r_state;
    logic [IDW_L-1:0]  r_ptr;
    logic [IDW_L-1:0]  r_gid;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [2*W-1:0]    r_p;

    logic [IDW_L-1:0]  w_gnt;
    logic              w_any;
    logic              w_wd_hit;

    rr_picker #(
        .NREQ  (NREQ),
        .IDW_L (IDW_L)
    ) u_picker (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_any (w_any)
    );

`ifdef MULT_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             r_wd_rst;

    // r_cnt is 0 in the first BUSY cycle, so TIMEOUT-1 marks the
    // TIMEOUT-th BUSY cycle without a done.
    assign w_wd_hit = (r_state == BUSY) && !mult_done &&
                      (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_wd_rst <= 1'b0;
        end else begin
            r_wd_rst <= 1'b0;
            case (r_state)
                ISSUE: r_cnt <= '0;
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mult_done) begin
                        r_err <= 1'b0;
                    end else if (w_wd_hit) begin
                        r_err    <= 1'b1;
                        r_wd_rst <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_err = rst_n && (r_state == RESP) && r_err;
    assign mult_rst = !rst_n || r_wd_rst;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
    assign w_wd_hit         = 1'b0;
    assign resp_err         = 1'b0;
    assign mult_rst         = !rst_n;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= req_a[w_gnt*W +: W];
                        r_b     <= req_b[w_gnt*W +: W];
                        r_gid   <= w_gnt;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: r_state <= BUSY;
                BUSY: begin
                    if (mult_done) begin
                        r_p     <= mult_p;
                        r_state <= RESP;
                    end else if (w_wd_hit) begin
                        r_p     <= '0;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_ptr   <= (r_gid == IDW_L'(NREQ - 1)) ? '0 : r_gid + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is held so nothing leaks out in the
    // first reset cycle, before the registers have cleared.
    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == IDLE) && w_any) req_ready[w_gnt] = 1'b1;
    end

    always_comb begin
        resp_valid = '0;
        if (rst_n && (r_state == RESP)) resp_valid[r_gid] = 1'b1;
    end

    assign mult_start = rst_n && (r_state == ISSUE);
    assign busy       = rst_n && (r_state != IDLE);
    assign mult_a     = rst_n ? r_a   : '0;
    assign mult_b     = rst_n ? r_b   : '0;
    assign resp_p     = rst_n ? r_p   : '0;
    assign grant_id   = rst_n ? r_gid : '0;

endmodule

// File: tb/tb_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_arbiter
// Random and directed requesters, a behavioural multiplier with variable
// latency, and a monitor that predicts grants round-robin from a pointer,
// queues expected products and compares every DUT strobe against them.
// ---------------------------------------------------------------------------
module tb_mult_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 256;
`ifdef MULT_ARB_WATCHDOG_EN
    localparam int TO = 20;
    localparam bit WD = 1'b1;
`else
    localparam int TO = 1023;
    localparam bit WD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid, req_ready, resp_valid;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [2*W-1:0]    resp_p, mult_p;
    logic              resp_err, mult_rst, mult_start, mult_done, busy;
    logic [W-1:0]      mult_a, mult_b;
    logic [1:0]        grant_id;
    logic              md_m = 1'b0, md_stray = 1'b0;
    logic [W-1:0]      opa [NREQ];
    logic [W-1:0]      opb [NREQ];

    assign mult_done = md_m | md_stray;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
        end
    end

    mult_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_p(resp_p), .resp_err(resp_err),
        .mult_rst(mult_rst), .mult_start(mult_start),
        .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_p(mult_p),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
        if ($urandom % 8 == 0) v = '1;
        if ($urandom % 8 == 1) v = W'($urandom % 16);
        return v;
    endfunction

    // ---------------- behavioural multiplier ----------------
    int lat  = 10;
    bit hang = 1'b0;

    initial begin : mult_model
        logic [W-1:0] pa, pb;
        int cnt;
        bit act;
        act = 1'b0; cnt = 0; pa = '0; pb = '0; mult_p = '0;
        forever begin
            @(posedge clk); #1;
            md_m = 1'b0;
            for (int k = 0; k < 16; k++) mult_p[k*32 +: 32] = $urandom;
            if (act) begin
                cnt--;
                if (cnt == 0) begin
                    md_m   = 1'b1;
                    mult_p = {{W{1'b0}}, pa} * {{W{1'b0}}, pb};
                    act    = 1'b0;
                end
            end
            @(negedge clk);
            if (mult_start === 1'b1 && !hang) begin
                pa = mult_a; pb = mult_b; cnt = lat; act = 1'b1;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int           id;
        logic [511:0] p;
        bit           err;
    } exp_t;

    exp_t sb [$];
    int   glog [$];
    bit   free = 1'b1, start_due = 1'b0, in_flight = 1'b0, resp_due = 1'b0, abort_due = 1'b0;
    int   ptr = 0, bcnt = 0, cyc = 0, acc_cyc = 0, resp_cyc = 0, n_starts = 0, last_g = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_mult_rst", mult_rst, 1);
                chk("rst_req_ready", req_ready, 0);
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_mult_start", mult_start, 0);
                chk("rst_busy", busy, 0);
                sb.delete();
                free = 1'b1; start_due = 1'b0; in_flight = 1'b0;
                resp_due = 1'b0; abort_due = 1'b0; ptr = 0; bcnt = 0;
            end else begin
                int g;
                bit nr, na;
                exp_t e;
                chk("busy", busy, !free);
                chk("mult_start", mult_start, start_due);
                chk("mult_rst", mult_rst, abort_due);
                chk("resp_strobe", |resp_valid, resp_due);
                if (start_due) chk("grant_id", grant_id, last_g);
                if (resp_due) begin
                    resp_cyc = cyc;
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL resp_unexpected: got resp_valid=%0h expected no response", resp_valid);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_onehot", resp_valid, 1 << e.id);
                        chk("resp_p", resp_p, e.p);
                        chk("resp_err", resp_err, e.err);
                        ptr = (e.id + 1) % NREQ;
                    end
                end
                // Round-robin prediction from the pointer, only when idle.
                g = -1;
                if (free)
                    for (int k = 0; k < NREQ; k++)
                        if (g < 0 && req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
                chk("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);

                nr = 1'b0; na = 1'b0;
                if (in_flight) begin
                    bcnt++;
                    if (mult_done) begin
                        nr = 1'b1; in_flight = 1'b0;
                    end else if (WD && bcnt == TO) begin
                        nr = 1'b1; na = 1'b1; in_flight = 1'b0;
                    end
                end
                if (start_due) begin
                    in_flight = 1'b1; bcnt = 0; n_starts++;
                end
                if (resp_due) free = 1'b1;
                start_due = 1'b0;
                if (g >= 0) begin
                    e.id  = g;
                    e.err = hang;
                    e.p   = hang ? '0 : {{W{1'b0}}, opa[g]} * {{W{1'b0}}, opb[g]};
                    sb.push_back(e);
                    glog.push_back(g);
                    free = 1'b0; start_due = 1'b1; acc_cyc = cyc; last_g = g;
                end
                resp_due  = nr;
                abort_due = na;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        logic [NREQ-1:0] rdy;
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk); #1;
        req_valid = req_valid & ~rdy;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        opa[i] = a; opb[i] = b; req_valid[i] = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(req_valid == 0 && free && !start_due && sb.size() == 0) && n < 3000) begin
            cycle(); n++;
        end
        chk(name, n < 3000, 1);
    endtask

    initial begin : main
        int base, ns, n;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        // single request, latency 10: accept t, resp t+12, 3*5=15
        lat = 10;
        set_req(0, 3, 5);
        wait_idle("single_done");
        chk("single_latency", resp_cyc - acc_cyc, 12);

        // all contend from pointer 0, operands held and re-requested
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        lat = 3;
        base = glog.size();
        for (int i = 0; i < NREQ; i++) set_req(i, rnd(), rnd());
        n = 0;
        while (glog.size() < base + 5 && n < 200) begin
            cycle(); n++;
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && glog.size() < base + 4) set_req(i, rnd(), rnd());
        end
        wait_idle("contend_done");
        chk("contend_count", glog.size() >= base + 5, 1);
        if (glog.size() >= base + 5) begin
            chk("contend_g0", glog[base], 0);
            chk("contend_g1", glog[base+1], 1);
            chk("contend_g2", glog[base+2], 2);
            chk("contend_g3", glog[base+3], 3);
            chk("contend_g4", glog[base+4], 0);
        end

        // wrap: serve 2 so pointer=3, then 1001 -> 3 then 0
        set_req(2, rnd(), rnd());
        wait_idle("wrap_pre");
        base = glog.size();
        set_req(3, rnd(), rnd());
        set_req(0, rnd(), rnd());
        wait_idle("wrap_done");
        chk("wrap_count", glog.size(), base + 2);
        if (glog.size() >= base + 2) begin
            chk("wrap_g0", glog[base], 3);
            chk("wrap_g1", glog[base+1], 0);
        end

        // reset one cycle before done
        lat = 10;
        ns = n_starts;
        set_req(1, rnd(), rnd());
        n = 0;
        while (n_starts == ns && n < 50) begin cycle(); n++; end
        chk("rst_mid_start_seen", n < 50, 1);
        repeat (8) cycle();
        rst_n = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();
        chk("rst_mid_busy_after", busy, 0);
        repeat (3) cycle();
        lat = 4;
        set_req(2, rnd(), rnd());
        wait_idle("rst_mid_fresh");

        // stray done while idle
        md_stray = 1'b1; cycle(); md_stray = 1'b0;
        repeat (3) cycle();
        chk("stray_busy", busy, 0);
        chk("stray_resp", resp_valid, 0);

`ifdef MULT_ARB_WATCHDOG_EN
        // multiplier never answers: abort at start+21 with err, p=0
        hang = 1'b1;
        set_req(3, rnd(), rnd());
        wait_idle("wd_done");
        hang = 1'b0;
        chk("wd_latency", resp_cyc - acc_cyc, TO + 2);
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            lat = $urandom_range(1, 12);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom % 3 == 0) set_req(i, rnd(), rnd());
                else if (req_valid[i] && $urandom % 40 == 0) req_valid[i] = 1'b0;
            end
            cycle();
        end
        req_valid = '0;
        wait_idle("random_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares the single 256x256 Karatsuba multiplier among NREQ requesters, e.g. the folding FSM, the coarse/fine reduction path and a future second reducer.
- Round-robin grant; latches operands, pulses the multiplier's start, waits for its done pulse, returns the 512-bit product to the granted requester.
- Sits between the requesters and the multiplier's start/done/P interface. The multiplier is never driven by more than one owner.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 256, operand width; product is 2W
- TIMEOUT, 1023, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot accept pulse
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing as req_a
- resp_valid  out  NREQ  one-hot, one-cycle product strobe
- resp_p  out  2W  product; valid while any resp_valid bit is high
- resp_err  out  1  watchdog abort flag, qualified by resp_valid
- mult_rst  out  1  multiplier reset
- mult_start  out  1  one-cycle start pulse
- mult_a  out  W  latched operand A
- mult_b  out  W  latched operand B
- mult_done  in  1  multiplier completion pulse
- mult_p  in  2W  multiplier product
- busy  out  1  high in every state except IDLE
- grant_id  out  clog2(NREQ)  index of the current owner

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr pointer=0.
  - All outputs 0 except mult_rst=1 for every cycle rst_n is low.
  - Reset mid-operation abandons the transaction; no resp_valid is issued for it.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - If any req_valid is set, grant g = first set bit scanning from the rr pointer upward, wrapping modulo NREQ.
  - Latch req_a[g] and req_b[g] into mult_a and mult_b; req_ready[g]=1 this cycle only; grant_id<=g; go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE: mult_start=1 for exactly one cycle; go to BUSY.
- BUSY:
  - Hold mult_a and mult_b stable.
  - On mult_done=1: resp_p<=mult_p; go to RESP.
- RESP:
  - resp_valid[g]=1 for one cycle; rr pointer <= (g+1) mod NREQ; go to IDLE.
  - resp_p holds its value until the next capture.
- Latency: accept at cycle t, mult_start at t+1. If mult_done arrives at cycle d, resp_valid is at d+1.
- Minimum spacing between accepts is 4 cycles (accept, ISSUE, done in the first BUSY cycle, RESP).
- Handshake:
  - A requester holds req_valid and its operands until it sees req_ready.
  - Dropping req_valid before the grant is legal; the request is simply not taken.
  - Operands are sampled only in the accept cycle.
- Boundary conditions:
  - mult_done outside BUSY is ignored.
  - mult_start is never asserted outside ISSUE.
  - Simultaneous requests resolve strictly round-robin, so no requester is granted twice while another is waiting.
  - A requester may re-request in the cycle its resp_valid is high; it competes normally in the following IDLE cycle.
  - Pointer wrap: g=NREQ-1 sets the pointer to 0.

Optional Feature:
- Macro: MULT_ARB_WATCHDOG_EN.
- With the macro defined:
  - A cycle counter runs in BUSY and clears on entry to BUSY.
  - If it reaches TIMEOUT with no mult_done: pulse mult_rst for one cycle, resp_p<=0, resp_err=1, go to RESP. resp_valid fires as normal.
  - A late mult_done after the abort is ignored.
- Without the macro: no counter; BUSY waits indefinitely; resp_err is tied to 0.

Decomposition:
- Shared package mult_arb_pkg holds:
  - the state enum (IDLE/ISSUE/BUSY/RESP)
  - localparam IDW = clog2(NREQ)
  - the default TIMEOUT
- One sub-module, rr_picker: combinational round-robin find-first-set from the pointer. Inputs req[NREQ] and ptr; outputs grant index and any-valid.

Test Plan:
- Single request: req_valid=4'b0001, A=3, B=5; model multiplier latency 10 -> req_ready[0] at t, mult_start at t+1, resp_valid[0] at t+12, resp_p=15, resp_err=0.
- All-contend: req_valid=4'b1111 held, pointer=0 -> grants in order 0,1,2,3,0; resp_p per requester equals that requester's A*B.
- Wrap: pointer at 3 after serving 2, req_valid=4'b1001 -> grant 3, then 0.
- Reset mid-BUSY: drop rst_n one cycle before mult_done -> no resp_valid, mult_rst=1 during reset, busy=0 after; a fresh request then completes normally.
- Stray done: pulse mult_done in IDLE with no requests -> no resp_valid, state stays IDLE.
- Watchdog (MULT_ARB_WATCHDOG_EN, TIMEOUT=20): multiplier never returns done -> mult_rst pulse, resp_valid with resp_err=1 and resp_p=0 at start+21.
